arcfour_engine: RTL
===================

// Module: arcfour_engine
// PURPOSE
//  Self-contained, parametrised RC4 (ARCFOUR) engine: S-box init, key schedule (KSA) and keystream
//  decrypt (PRGA) in one FSM, driving external S RAM, ciphertext ROM and plaintext RAM. Key length is
//  a runtime input. Optional CHECK mode aborts on the first non-printable plaintext byte, so a key-search
//  wrapper can instantiate NUM_CORES copies and sweep keys. Sits under the decryption top level.
// PARAMETERS
//  KEY_MAX   3   maximum key bytes; key_len selects 1..KEY_MAX at runtime
//  MSG_LEN   32  ciphertext/plaintext bytes processed per run (>=1)
//  MSG_AW    $clog2(MSG_LEN)  ROM/A address width
//  CHK_LO    8'h61  CHECK mode: lowest accepted plaintext byte ('a')
//  CHK_HI    8'h7A  CHECK mode: highest accepted byte ('z'); 8'h20 (space) always accepted
// PORTS
//  clk      in   1          clock, all state on rising edge
//  reset    in   1          asynchronous, active-low reset
//  start    in   1          1-cycle pulse; sampled only in IDLE
//  mode     in   1          0 = FULL (decrypt all), 1 = CHECK (abort on bad byte); latched at start
//  key      in   KEY_MAX*8  key[n*8+:8] = key byte n; latched at start
//  key_len  in   $clog2(KEY_MAX+1)  active key bytes; latched at start
//  busy     out  1          high from cycle after accepted start until done
//  done     out  1          1-cycle pulse at end of run
//  key_ok   out  1          valid with done, held until next start: 1 = all MSG_LEN bytes passed/decrypted
//  err      out  1          pulses with done if key_len==0 or >KEY_MAX (run not performed)
//  s_addr   out  8   s_din out 8   s_wren out 1   s_dout in 8   S RAM, 256x8, read data 1 cycle after addr
//  k_addr   out  MSG_AW     ciphertext ROM addr;   k_dout in 8, valid 1 cycle after addr
//  a_addr   out  MSG_AW   a_din out 8   a_wren out 1   plaintext RAM write port
// BEHAVIOUR
//  Reset: FSM=IDLE; busy,done,key_ok,err,s_wren,a_wren=0; all addr/data outputs=0; i,j,k=0.
//  IDLE: start=1 -> latch key/key_len/mode; invalid key_len -> DONE with err=1; else INIT, busy=1.
//  INIT: write S[n]=n, n=0..255, one write/cycle (256 cycles).
//  KSA: for i=0..255: j = j + S[i] + key[i mod key_len] (mod 256); swap S[i],S[j]. i mod key_len is a
//   separate wrapping counter (no divider). Swap sequence per step: RD_I, RD_J, WR_I(S[j]), WR_J(S[i]).
//  PRGA: i=j=0; for k=0..MSG_LEN-1: i=i+1; j=j+S[i]; swap; read S[(S[i]+S[j]) mod 256] -> f;
//   a[k] = f ^ ROM[k] (a_wren 1 cycle). ROM[k] read overlaps S reads.
//  CHECK mode: after each a write, byte outside [CHK_LO,CHK_HI] and !=8'h20 -> DONE, key_ok=0, no further
//   writes. FULL mode never aborts; key_ok=1 at end. CHECK reaching k=MSG_LEN -> key_ok=1.
//  DONE: done=1 one cycle, busy=0 same cycle, -> IDLE. key_ok/err hold until next accepted start.
//  All 8-bit index arithmetic wraps mod 256; i==j swap is legal (writes same value twice).
//  start while busy: ignored. reset mid-run: immediate IDLE; S/A contents undefined, not cleared.
//  Never s_wren and a read-data-dependent decision in same cycle for same address (RAM is read-old).
//  Latency (FULL): 1 + 256 + 256*4 + MSG_LEN*6 + 1 cycles from start to done; bench checks exactly.
// STRUCTURE
//  arcfour_pkg: fsm_state_t enum (IDLE, INIT, KSA, PRGA, DONE), swap_phase_t (RD_I,RD_J,WR_I,WR_J),
//   mode_t (FULL, CHECK), constant SBOX_DEPTH=256.
//  Sub-module arcfour_swap_unit: owns RD_I/RD_J/WR_I/WR_J sequencing and S port muxing, shared by KSA and
//   PRGA; takes i and j-increment source, returns S[i],S[j], pulses swap_done.
// TESTING
//  1. FULL, key="Key" (4B 65 79), key_len=3, MSG_LEN=9, ROM=BB F3 16 E8 D9 40 AF 0A D3 -> A="Plaintext",
//     key_ok=1, done after 1+256+1024+54+1 cycles.
//  2. CHECK, same ROM, key=4B 65 78 (wrong) -> done early, key_ok=0, a_wren count < 9.
//  3. key_len=0 and key_len=KEY_MAX+1 -> done with err=1 within 2 cycles, no s_wren ever asserted.
//  4. key_len=1 vs key_len=3 with key bytes all equal -> identical plaintext (modulo counter wrap).
//  5. Assert reset low mid-KSA -> outputs to reset values same edge; new start runs test 1 correctly.
//  6. start pulses during busy -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/arcfour_pkg.sv
// arcfour_pkg: shared types for the RC4 engine.
// Holds the FSM states, swap phases, run modes, S-box depth and the byte filter.
package arcfour_pkg;
   localparam int SBOX_DEPTH = 256;

   typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, DONE} fsm_state_t;
   typedef enum logic [1:0] {RD_I, RD_J, WR_I, WR_J} swap_phase_t;
   typedef enum logic {FULL, CHECK} mode_t;

   function automatic logic byte_ok(
      input logic [7:0] b,
      input logic [7:0] lo,
      input logic [7:0] hi
   );
      return ((b >= lo) && (b <= hi)) || (b == 8'h20);
   endfunction
endpackage

// File: rtl/arcfour_swap_unit.sv
// arcfour_swap_unit: RD_I/RD_J/WR_I/WR_J swap of S[i],S[j], owns j and S port mux.
// Ports: go runs phases, i/inc in, ext_* used when idle, si/sj out, swap_done on WR_J.
module arcfour_swap_unit
   import arcfour_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       go,
   input  logic       j_clr,
   input  logic [7:0] i,
   input  logic [7:0] inc,
   input  logic [7:0] ext_addr,
   input  logic [7:0] ext_din,
   input  logic       ext_wren,
   input  logic [7:0] s_dout,
   output logic [7:0] s_addr,
   output logic [7:0] s_din,
   output logic       s_wren,
   output logic [7:0] si,
   output logic [7:0] sj,
   output logic       swap_done
);
   swap_phase_t phase, phase_n;
   logic [7:0]  j;
   logic [7:0]  j_nxt;

   // s_dout holds S[i] during RD_J
   assign j_nxt = j + s_dout + inc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase <= RD_I;
         j     <= '0;
         si    <= '0;
         sj    <= '0;
      end else begin
         phase <= phase_n;
         if (j_clr)
            j <= '0;
         else if (go && phase == RD_J)
            j <= j_nxt;
         if (go && phase == RD_J)
            si <= s_dout;
         if (go && phase == WR_I)
            sj <= s_dout;
      end
   end

   always_comb begin
      phase_n   = RD_I;
      s_addr    = ext_addr;
      s_din     = ext_din;
      s_wren    = ext_wren;
      swap_done = 1'b0;
      if (go) begin
         unique case (phase)
            RD_I: begin
               phase_n = RD_J;
               s_addr  = i;
               s_din   = '0;
               s_wren  = 1'b0;
            end
            RD_J: begin
               phase_n = WR_I;
               s_addr  = j_nxt;
               s_din   = '0;
               s_wren  = 1'b0;
            end
            WR_I: begin
               phase_n = WR_J;
               s_addr  = i;
               s_din   = s_dout;
               s_wren  = 1'b1;
            end
            WR_J: begin
               phase_n   = RD_I;
               s_addr    = j;
               s_din     = si;
               s_wren    = 1'b1;
               swap_done = 1'b1;
            end
         endcase
      end
   end
endmodule

// File: rtl/arcfour_engine.sv
// arcfour_engine: RC4 init/KSA/PRGA over external S RAM, cipher ROM, plain RAM.
// Ports: start/mode/key/key_len in; busy/done/key_ok/err out; s_*, k_*, a_* memories.
module arcfour_engine
   import arcfour_pkg::*;
#(
   parameter int         KEY_MAX = 3,
   parameter int         MSG_LEN = 32,
   parameter int         MSG_AW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
   parameter logic [7:0] CHK_LO  = 8'h61,
   parameter logic [7:0] CHK_HI  = 8'h7A
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         mode,
   input  logic [KEY_MAX*8-1:0]         key,
   input  logic [$clog2(KEY_MAX+1)-1:0] key_len,
   output logic                         busy,
   output logic                         done,
   output logic                         key_ok,
   output logic                         err,
   output logic [7:0]                   s_addr,
   output logic [7:0]                   s_din,
   output logic                         s_wren,
   input  logic [7:0]                   s_dout,
   output logic [MSG_AW-1:0]            k_addr,
   input  logic [7:0]                   k_dout,
   output logic [MSG_AW-1:0]            a_addr,
   output logic [7:0]                   a_din,
   output logic                         a_wren
);
   localparam int KL_W = $clog2(KEY_MAX+1);
   localparam int KB_N = 1 << KL_W;
   localparam logic [7:0] LAST_N = 8'(SBOX_DEPTH-1);
   localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN-1);

   fsm_state_t        state, state_n;
   mode_t             mode_q;
   logic [7:0]        i;
   logic [MSG_AW-1:0] k;
   logic [KL_W-1:0]   kidx;
   logic [KL_W-1:0]   kl_q;
   logic [1:0]        ptail;
   logic [7:0]        key_b [KB_N];

   logic       kl_ok, go, j_clr, ext_wren, swap_done, abort;
   logic [7:0] ext_addr, ext_din, inc, si, sj, pt;

   assign kl_ok  = (key_len != '0) && (key_len <= KL_W'(KEY_MAX));
   assign inc    = (state == KSA) ? key_b[kidx] : 8'h00;
   assign pt     = s_dout ^ k_dout;
   assign abort  = (mode_q == CHECK) && !byte_ok(pt, CHK_LO, CHK_HI);
   assign k_addr = k;
   assign a_addr = a_wren ? k : '0;

   arcfour_swap_unit u_swap (
      .clk       (clk),
      .reset     (reset),
      .go        (go),
      .j_clr     (j_clr),
      .i         (i),
      .inc       (inc),
      .ext_addr  (ext_addr),
      .ext_din   (ext_din),
      .ext_wren  (ext_wren),
      .s_dout    (s_dout),
      .s_addr    (s_addr),
      .s_din     (s_din),
      .s_wren    (s_wren),
      .si        (si),
      .sj        (sj),
      .swap_done (swap_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         mode_q <= FULL;
         i      <= '0;
         k      <= '0;
         kidx   <= '0;
         kl_q   <= '0;
         ptail  <= '0;
         key_ok <= 1'b0;
         err    <= 1'b0;
         for (int n = 0; n < KB_N; n++)
            key_b[n] <= '0;
      end else begin
         state <= state_n;
         unique case (state)
            IDLE: begin
               if (start) begin
                  for (int n = 0; n < KEY_MAX; n++)
                     key_b[n] <= key[n*8 +: 8];
                  kl_q   <= key_len;
                  mode_q <= mode_t'(mode);
                  err    <= !kl_ok;
                  key_ok <= 1'b0;
                  i      <= '0;
                  k      <= '0;
                  kidx   <= '0;
                  ptail  <= '0;
               end
            end
            INIT: i <= i + 8'd1;
            KSA: begin
               if (swap_done) begin
                  // PRGA starts with i already pre-incremented
                  i    <= (i == LAST_N) ? 8'd1 : i + 8'd1;
                  kidx <= (kidx == kl_q - 1'b1) ? '0 : kidx + 1'b1;
               end
            end
            PRGA: begin
               unique case (ptail)
                  2'd0: if (swap_done) ptail <= 2'd1;
                  2'd1: ptail <= 2'd2;
                  default: begin
                     ptail <= 2'd0;
                     i     <= i + 8'd1;
                     k     <= k + 1'b1;
                     if (abort || k == K_LAST)
                        key_ok <= !abort;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_n  = state;
      busy     = 1'b0;
      done     = 1'b0;
      go       = 1'b0;
      j_clr    = 1'b0;
      ext_addr = '0;
      ext_din  = '0;
      ext_wren = 1'b0;
      a_wren   = 1'b0;
      a_din    = '0;
      unique case (state)
         IDLE: begin
            if (start) begin
               j_clr   = 1'b1;
               state_n = kl_ok ? INIT : DONE;
            end
         end
         INIT: begin
            busy     = 1'b1;
            ext_addr = i;
            ext_din  = i;
            ext_wren = 1'b1;
            if (i == LAST_N)
               state_n = KSA;
         end
         KSA: begin
            busy = 1'b1;
            go   = 1'b1;
            if (swap_done && i == LAST_N) begin
               j_clr   = 1'b1;
               state_n = PRGA;
            end
         end
         PRGA: begin
            busy = 1'b1;
            go   = (ptail == 2'd0);
            // after the swap si+sj equals new S[i]+S[j]
            if (ptail == 2'd1)
               ext_addr = si + sj;
            if (ptail == 2'd2) begin
               a_wren = 1'b1;
               a_din  = pt;
               if (abort || k == K_LAST)
                  state_n = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule
